// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
// Imported by the divider interface, the step datapath and the top.
package div_pkg;

  localparam int DIV_N = 16;

  function automatic int cnt_width(input int n);
    return $clog2(2 * n);
  endfunction

  localparam int DIV_CW = cnt_width(DIV_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage : div_pkg

// File: rtl/restoring_divider_16_if.sv
// Operand/result handshake bundle for the restoring divider.
// The divider itself uses the slave modport; its requester uses master.
interface restoring_divider_16_if
  import div_pkg::*;
#(
  parameter int N = DIV_N
);

  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   dividend;
  logic [N-1:0]     divisor;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   quotient;
  logic [N-1:0]     remainder;
  logic             div_by_zero;

  modport slave (
    input  in_valid,
    input  dividend,
    input  divisor,
    input  out_ready,
    output in_ready,
    output out_valid,
    output quotient,
    output remainder,
    output div_by_zero
  );

  modport master (
    output in_valid,
    output dividend,
    output divisor,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

endinterface : restoring_divider_16_if

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits, and report the resulting quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N:0]   r,
  input  logic         dividend_bit,
  input  logic [N-1:0] divisor,
  output logic [N:0]   r_next,
  output logic         q_bit
);

  logic [N:0] shifted_s;
  logic [N:0] diff_s;
  logic       fits_s;

  // r stays below the divisor, so its top bit is zero in practice; folding it
  // into the compare keeps the step correct even for an out-of-range r.
  always_comb begin
    shifted_s = {r[N-1:0], dividend_bit};
    diff_s    = shifted_s - {1'b0, divisor};
    fits_s    = r[N] | (shifted_s >= {1'b0, divisor});
    if (fits_s) begin
      r_next = diff_s;
      q_bit  = 1'b1;
    end else begin
      r_next = shifted_s;
      q_bit  = 1'b0;
    end
  end

endmodule : div_step

// File: rtl/restoring_divider_16.sv
// Sequential 2N/N restoring divider retiring one quotient bit per clock,
// with valid/ready handshakes on the operand and result sides.
module restoring_divider_16
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input logic                 clk,
  input logic                 rst_n,
  restoring_divider_16_if.slave bus
);

  localparam int            CW       = cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * N - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  div_state_e       state_r;
  logic [CW-1:0]    count_r;
  logic [2*N-1:0]   dq_r;
  logic [N-1:0]     dvs_r;
  logic [N:0]       rem_r;

  logic             in_ready_r;
  logic             out_valid_r;
  logic [2*N-1:0]   quotient_r;
  logic [N-1:0]     remainder_r;
  logic             dbz_r;

  logic [N:0]       step_r_s;
  logic             step_q_s;

  // The dividend leaves dq_r from the top while quotient bits enter at the
  // bottom, so after 2N steps dq_r holds exactly the quotient.
  div_step #(
    .N (N)
  ) u_step (
    .r            (rem_r),
    .dividend_bit (dq_r[2*N-1]),
    .divisor      (dvs_r),
    .r_next       (step_r_s),
    .q_bit        (step_q_s)
  );

  // Control FSM, datapath shift registers and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      count_r     <= CNT_ZERO;
      dq_r        <= {(2*N){1'b0}};
      dvs_r       <= {N{1'b0}};
      rem_r       <= {(N+1){1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      quotient_r  <= {(2*N){1'b0}};
      remainder_r <= {N{1'b0}};
      dbz_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            dq_r       <= bus.dividend;
            dvs_r      <= bus.divisor;
            rem_r      <= {(N+1){1'b0}};
            count_r    <= CNT_LAST;
            in_ready_r <= 1'b0;
            if (bus.divisor == {N{1'b0}}) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
              quotient_r  <= {(2*N){1'b1}};
              remainder_r <= bus.dividend[N-1:0];
              dbz_r       <= 1'b1;
            end else begin
              state_r <= BUSY;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        BUSY: begin
          rem_r   <= step_r_s;
          dq_r    <= {dq_r[2*N-2:0], step_q_s};
          count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
          if (count_r == CNT_ZERO) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            quotient_r  <= {dq_r[2*N-2:0], step_q_s};
            remainder_r <= step_r_s[N-1:0];
            dbz_r       <= 1'b0;
          end else begin
            state_r <= BUSY;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end else begin
            state_r <= DONE;
          end
        end

        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;

endmodule : restoring_divider_16

// File: tb/tb_restoring_divider_16.sv
// Directed self-checking bench for restoring_divider_16: hand-computed
// quotients/remainders, latency, back-pressure, divide-by-zero and reset abort.
module tb_restoring_divider_16;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;

  restoring_divider_16_if #(.N(16)) bus ();

  restoring_divider_16 #(.N(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands so they are taken on the next rising edge (E0).
  task automatic start(input logic [31:0] dvd, input logic [15:0] dvs);
    bus.dividend = dvd;
    bus.divisor  = dvs;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Count edges after E0 until out_valid, bounded.
  task automatic wait_done();
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] dvd, input logic [15:0] dvs,
                     input logic [31:0] eq, input logic [15:0] er, input logic ed,
                     input int elat);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    start(dvd, dvs);
    wait_done();
    chk({tag, "_latency"}, cyc, elat);
    chk({tag, "_quotient"}, bus.quotient, eq);
    chk({tag, "_remainder"}, bus.remainder, er);
    chk({tag, "_dbz"}, bus.div_by_zero, ed);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_drop_valid"}, bus.out_valid, 0);
    chk({tag, "_ready_back"}, bus.in_ready, 1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = 32'h0;
    bus.divisor   = 16'h0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_quotient", bus.quotient, 0);
    chk("rst_remainder", bus.remainder, 0);
    chk("rst_dbz", bus.div_by_zero, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run("d100_7", 32'd100, 16'd7, 32'd14, 16'd2, 1'b0, 32);
    run("max_sq", 32'hFFFE_0001, 16'hFFFF, 32'h0000_FFFF, 16'h0, 1'b0, 32);
    run("prod_a", 32'd670592745, 16'd54321, 32'd12345, 16'd0, 1'b0, 32);
    run("prod_b", 32'd2000000000, 16'd50000, 32'd40000, 16'd0, 1'b0, 32);
    run("prod_b7", 32'd2000000007, 16'd50000, 32'd40000, 16'd7, 1'b0, 32);
    run("small", 32'd5, 16'd7, 32'd0, 16'd5, 1'b0, 32);
    run("dbz", 32'h1234_5678, 16'h0, 32'hFFFF_FFFF, 16'h5678, 1'b1, 0);
    run("after_dbz", 32'd0, 16'd3, 32'd0, 16'd0, 1'b0, 32);
    run("by_one", 32'hFFFF_FFFF, 16'd1, 32'hFFFF_FFFF, 16'h0, 1'b0, 32);
    run("by_ffff", 32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'h0, 1'b0, 32);

    // Back-pressure: operands changed while busy, in_valid pulses while done.
    start(32'd1000, 16'd10);
    bus.dividend = 32'h0000_DEAD;
    bus.divisor  = 16'd3;
    wait_done();
    chk("hold_latency", cyc, 32);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      @(posedge clk);
      #1;
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_quotient", bus.quotient, 100);
      chk("hold_remainder", bus.remainder, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("hold_release_ready", bus.in_ready, 1);
    chk("hold_release_valid", bus.out_valid, 0);
    chk("hold_keep_quotient", bus.quotient, 100);
    @(posedge clk);
    #1;
    chk("hold_idle_stays", bus.in_ready, 1);

    // Reset ten steps into a division, then a fresh division.
    start(32'h1234_5678, 16'h1234);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy", bus.in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_quotient", bus.quotient, 0);
    chk("abort_remainder", bus.remainder, 0);
    chk("abort_dbz", bus.div_by_zero, 0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run("post_rst", 32'h1234_5678, 16'h1234, 32'd65540, 16'd3496, 1'b0, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_restoring_divider_16
